inert_seq: RTL and testbench

- SPI transaction sequencer that sits in front of `inertial_integrator`.
- After reset, waits a power-up delay, then configures the inertial sensor with a fixed 4-write init sequence.
- On each sensor data-ready interrupt, performs 4 register reads (pitch-rate low/high, AZ low/high), assembles 16-bit samples, and issues the one-cycle `vld` that advances the integrator.
- Drives an external SPI master through a `wrt`/`done` command handshake.

---
 rtl/inert_pkg.sv | 30 +++
 rtl/sync2.sv | 29 ++
 rtl/inert_seq.sv | 145 ++++++++++++++
 tb/tb_inert_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inert_pkg.sv
// rtl/inert_pkg.sv - shared types and command tables for the inertial sensor sequencer
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_CMD,
        INIT_WAIT,
        IDLE,
        RD_CMD,
        RD_WAIT,
        DATA_VLD
    } inert_state_t;

    localparam logic [7:0] RD_BIT = 8'h80;
    localparam logic [7:0] PTCH_L = 8'h22;
    localparam logic [7:0] PTCH_H = 8'h23;
    localparam logic [7:0] AZ_L   = 8'h2C;
    localparam logic [7:0] AZ_H   = 8'h2D;

    localparam logic [15:0] INIT_TBL [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

    // Byte order matches the byte register index: ptch L/H then AZ L/H.
    localparam logic [15:0] RD_TBL [4] = '{
        {RD_BIT | PTCH_L, 8'h00},
        {RD_BIT | PTCH_H, 8'h00},
        {RD_BIT | AZ_L,   8'h00},
        {RD_BIT | AZ_H,   8'h00}
    };

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous level
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/inert_seq.sv
// rtl/inert_seq.sv - SPI init and read-burst sequencer feeding the inertial integrator
module inert_seq
    import inert_pkg::*;
#(
    parameter int TMR_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] inert_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    logic int_s;

    sync2 u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .q     (int_s)
    );

    inert_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       byte_q [4];
    logic [7:0]       byte_d [4];
    logic             wrt_q, wrt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             vld_q, vld_d;
    logic [15:0]      ptch_q, ptch_d;
    logic [15:0]      az_q, az_d;

    logic unused_hi_data;
    assign unused_hi_data = &{1'b0, inert_data[15:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR_WAIT;
            timer_q <= '0;
            idx_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                byte_q[i] <= 8'h00;
            end
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            vld_q   <= 1'b0;
            ptch_q  <= 16'h0000;
            az_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 4; i++) begin
                byte_q[i] <= byte_d[i];
            end
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            ptch_q  <= ptch_d;
            az_q    <= az_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        for (int i = 0; i < 4; i++) begin
            byte_d[i] = byte_q[i];
        end

        case (state_q)
            PWR_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (&timer_q) begin
                    state_d = INIT_CMD;
                    idx_d   = 2'd0;
                end
            end
            INIT_CMD: state_d = INIT_WAIT;
            INIT_WAIT: begin
                if (done) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = INIT_CMD;
                    end
                end
            end
            IDLE: begin
                if (int_s) begin
                    state_d = RD_CMD;
                    idx_d   = 2'd0;
                end
            end
            RD_CMD: state_d = RD_WAIT;
            RD_WAIT: begin
                if (done) begin
                    byte_d[idx_q] = inert_data[7:0];
                    if (idx_q == 2'd3) begin
                        state_d = DATA_VLD;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = RD_CMD;
                    end
                end
            end
            DATA_VLD: state_d = IDLE;
            default:  state_d = PWR_WAIT;
        endcase
    end

    // Outputs are registered off the next state so wrt/vld line up with *_CMD/DATA_VLD
    // and the samples update on the very edge that raises vld.
    always_comb begin
        wrt_d  = (state_d == INIT_CMD) || (state_d == RD_CMD);
        vld_d  = (state_d == DATA_VLD);
        cmd_d  = cmd_q;
        ptch_d = ptch_q;
        az_d   = az_q;
        if (state_d == INIT_CMD) begin
            cmd_d = INIT_TBL[idx_d];
        end else if (state_d == RD_CMD) begin
            cmd_d = RD_TBL[idx_d];
        end
        if (vld_d) begin
            ptch_d = {byte_d[1], byte_d[0]};
            az_d   = {byte_d[3], byte_d[2]};
        end
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inert_seq.sv
// tb/tb_inert_seq.sv - randomized self-checking bench for inert_seq with an SPI slave model
module tb_inert_seq;

    localparam int TMR_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done_a = 1'b0;
    logic        done_s = 1'b0;
    logic [15:0] data_a = 16'h0000;
    logic [15:0] data_s = 16'h0000;
    logic        done;
    logic [15:0] inert_data;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    assign done       = done_a | done_s;
    assign inert_data = done_a ? data_a : data_s;

    inert_seq #(.TMR_W(TMR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .INT        (INT),
        .done       (done),
        .inert_data (inert_data),
        .wrt        (wrt),
        .cmd        (cmd),
        .vld        (vld),
        .ptch_rt    (ptch_rt),
        .AZ         (AZ)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_pass = 0;

    logic [15:0] init_exp [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [15:0] rd_exp [4]   = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    int          wrt_e[$];
    logic [15:0] wrt_c[$];
    int          done_e[$];
    logic [15:0] done_c[$];
    logic [7:0]  done_b[$];
    int          vld_e[$];
    logic [15:0] vld_p[$];
    logic [15:0] vld_a[$];
    int          exp_e[$];
    logic [15:0] exp_p[$];
    logic [15:0] exp_a[$];
    logic [7:0]  force_q[$];
    int          leak_errs = 0;
    bit          spi_busy = 1'b0;
    int          rel_edge = 0;

    // Observes the bus away from the active edge; samples may only move with vld.
    initial begin : monitor
        logic [15:0] prev_p, prev_a;
        prev_p = 16'h0;
        prev_a = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_p = 16'h0;
                prev_a = 16'h0;
            end else begin
                if (wrt === 1'b1) begin
                    wrt_e.push_back(edge_cnt);
                    wrt_c.push_back(cmd);
                end
                if (vld === 1'b1) begin
                    vld_e.push_back(edge_cnt);
                    vld_p.push_back(ptch_rt);
                    vld_a.push_back(AZ);
                end else if (ptch_rt !== prev_p || AZ !== prev_a) begin
                    leak_errs++;
                end
                prev_p = ptch_rt;
                prev_a = AZ;
            end
        end
    end

    // SPI slave: done is sampled by the DUT 8 clocks after the edge that raised wrt.
    initial begin : spi_slave
        logic [15:0] c;
        logic [7:0]  b;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (wrt === 1'b1 && rst_n) begin
                c = cmd;
                spi_busy = 1'b1;
                aborted = 1'b0;
                repeat (7) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) aborted = 1'b1;
                end
                if (!aborted && rst_n) begin
                    if (c[15] && force_q.size() > 0) b = force_q.pop_front();
                    else b = 8'($urandom);
                    data_a = {8'($urandom), b};
                    done_a = 1'b1;
                    done_e.push_back(edge_cnt + 1);
                    done_c.push_back(c);
                    done_b.push_back(b);
                    @(posedge clk);
                    #1;
                    done_a = 1'b0;
                end
                spi_busy = 1'b0;
            end
        end
    end

    // Sensor register-file view: each read updates a register; reading AZ_H completes a sample.
    function automatic void build_exp();
        logic [7:0] regs [256];
        logic [7:0] a;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        exp_e.delete();
        exp_p.delete();
        exp_a.delete();
        for (int i = 0; i < done_c.size(); i++) begin
            if (done_c[i][15]) begin
                a = {1'b0, done_c[i][14:8]};
                regs[a] = done_b[i];
                if (a == 8'h2D) begin
                    exp_e.push_back(done_e[i]);
                    exp_p.push_back({regs[8'h23], regs[8'h22]});
                    exp_a.push_back({regs[8'h2D], regs[8'h2C]});
                end
            end
        end
    endfunction

    task automatic clear_logs();
        wrt_e.delete(); wrt_c.delete();
        done_e.delete(); done_c.delete(); done_b.delete();
        vld_e.delete(); vld_p.delete(); vld_a.delete();
        leak_errs = 0;
    endtask

    task automatic wait_wrts(input int n, input int budget, output bit ok);
        int k = 0;
        while (wrt_e.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        ok = (wrt_e.size() >= n);
    endtask

    task automatic wait_vlds(input int n, input int budget, output bit ok);
        int k = 0;
        while (vld_e.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        ok = (vld_e.size() >= n);
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        int k = 0;
        int quiet = 0;
        while (quiet < 20 && k < budget) begin
            @(posedge clk);
            #1;
            if (wrt || spi_busy || done) quiet = 0;
            else quiet++;
            k++;
        end
        ok = (quiet >= 20);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel_edge = edge_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        INT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wrt !== 1'b0) $display("FAIL reset_wrt: got %b want 0", wrt); else n_pass++;
        n_checks++; if (cmd !== 16'h0) $display("FAIL reset_cmd: got %h want 0000", cmd); else n_pass++;
        n_checks++; if (vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", vld); else n_pass++;
        n_checks++; if (ptch_rt !== 16'h0) $display("FAIL reset_ptch: got %h want 0000", ptch_rt); else n_pass++;
        n_checks++; if (AZ !== 16'h0) $display("FAIL reset_az: got %h want 0000", AZ); else n_pass++;
    endtask

    task automatic test_init_int_early();
        bit ok;
        int bad;
        clear_logs();
        INT = 1'b1;
        release_reset();
        wait_wrts(2, 200, ok);
        INT = 1'b0;
        wait_wrts(4, 200, ok);
        n_checks++; if (!ok) $display("FAIL init_wrt_count: got %0d want 4", wrt_e.size()); else n_pass++;
        wait_quiet(400, ok);
        n_checks++; if (!ok) $display("FAIL init_quiet: got busy want quiet"); else n_pass++;
        n_checks++; if (wrt_c.size() != 4) $display("FAIL init_no_reads: got %0d cmds want 4", wrt_c.size()); else n_pass++;
        n_checks++; if (vld_e.size() != 0) $display("FAIL init_no_vld: got %0d want 0", vld_e.size()); else n_pass++;
        if (wrt_e.size() >= 4 && done_e.size() >= 3) begin
            n_checks++;
            if (wrt_e[0] - rel_edge != 16)
                $display("FAIL init_first_wrt: got %0d want 16", wrt_e[0] - rel_edge);
            else n_pass++;
            bad = 0;
            for (int i = 0; i < 4; i++) if (wrt_c[i] !== init_exp[i]) bad++;
            n_checks++; if (bad != 0) $display("FAIL init_cmds: got %0d wrong want 0", bad); else n_pass++;
            bad = 0;
            for (int i = 1; i < 4; i++) if (wrt_e[i] != done_e[i-1]) bad++;
            n_checks++; if (bad != 0) $display("FAIL init_spacing: got %0d wrong want 0", bad); else n_pass++;
        end
    endtask

    task automatic test_single_read();
        bit ok;
        int bad;
        clear_logs();
        force_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        INT = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        INT = 1'b0;
        wait_vlds(1, 300, ok);
        n_checks++; if (!ok) $display("FAIL single_vld_seen: got timeout want vld"); else n_pass++;
        wait_quiet(400, ok);
        n_checks++; if (wrt_c.size() != 4) $display("FAIL single_rd_count: got %0d want 4", wrt_c.size()); else n_pass++;
        n_checks++; if (vld_e.size() != 1) $display("FAIL single_vld_count: got %0d want 1", vld_e.size()); else n_pass++;
        if (wrt_c.size() == 4 && vld_e.size() == 1 && done_e.size() == 4) begin
            bad = 0;
            for (int i = 0; i < 4; i++) if (wrt_c[i] !== rd_exp[i]) bad++;
            n_checks++; if (bad != 0) $display("FAIL single_rd_cmds: got %0d wrong want 0", bad); else n_pass++;
            n_checks++; if (vld_e[0] != done_e[3]) $display("FAIL single_vld_latency: got %0d want %0d", vld_e[0], done_e[3]); else n_pass++;
            n_checks++; if (vld_p[0] !== 16'h1234) $display("FAIL single_ptch: got %h want 1234", vld_p[0]); else n_pass++;
            n_checks++; if (vld_a[0] !== 16'h5678) $display("FAIL single_az: got %h want 5678", vld_a[0]); else n_pass++;
        end
        n_checks++; if (leak_errs != 0) $display("FAIL single_leak: got %0d want 0", leak_errs); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad, k;
        clear_logs();
        INT = 1'b1;
        wait_vlds(1, 300, ok);
        force_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        wait_vlds(3, 400, ok);
        n_checks++; if (!ok) $display("FAIL b2b_vld_seen: got %0d want 3", vld_e.size()); else n_pass++;
        INT = 1'b0;
        wait_quiet(600, ok);
        build_exp();
        n_checks++; if (vld_e.size() != exp_e.size()) $display("FAIL b2b_vld_count: got %0d want %0d", vld_e.size(), exp_e.size()); else n_pass++;
        n_checks++; if (wrt_c.size() != 4 * vld_e.size()) $display("FAIL b2b_reads_per_vld: got %0d want %0d", wrt_c.size(), 4 * vld_e.size()); else n_pass++;
        bad = 0;
        k = 0;
        foreach (wrt_c[i]) begin
            if (wrt_c[i] !== rd_exp[k % 4]) bad++;
            k++;
        end
        n_checks++; if (bad != 0) $display("FAIL b2b_rd_order: got %0d wrong want 0", bad); else n_pass++;
        if (vld_e.size() == exp_e.size() && vld_e.size() >= 3 && wrt_e.size() >= 5) begin
            bad = 0;
            for (int i = 0; i < vld_e.size(); i++)
                if (vld_p[i] !== exp_p[i] || vld_a[i] !== exp_a[i] || vld_e[i] != exp_e[i]) bad++;
            n_checks++; if (bad != 0) $display("FAIL b2b_samples: got %0d wrong want 0", bad); else n_pass++;
            n_checks++; if (wrt_e[4] != vld_e[0] + 2) $display("FAIL b2b_restart: got %0d want %0d", wrt_e[4], vld_e[0] + 2); else n_pass++;
            n_checks++; if (vld_p[1] !== 16'hFFFF || vld_a[1] !== 16'hFFFF) $display("FAIL b2b_ff_burst: got %h/%h want ffff/ffff", vld_p[1], vld_a[1]); else n_pass++;
        end
        n_checks++; if (leak_errs != 0) $display("FAIL b2b_leak: got %0d want 0", leak_errs); else n_pass++;
    endtask

    task automatic test_spurious();
        bit ok;
        int bad, k;
        clear_logs();
        repeat (3) begin
            @(posedge clk);
            #1;
            data_s = 16'hEEEE;
            done_s = 1'b1;
            @(posedge clk);
            #1;
            done_s = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (wrt_e.size() != 0) $display("FAIL spur_idle_wrt: got %0d want 0", wrt_e.size()); else n_pass++;
        n_checks++; if (vld_e.size() != 0) $display("FAIL spur_idle_vld: got %0d want 0", vld_e.size()); else n_pass++;
        INT = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (wrt !== 1'b1 && k < 50);
        data_s = 16'hEEEE;
        done_s = 1'b1;
        @(posedge clk);
        #1;
        done_s = 1'b0;
        INT = 1'b0;
        wait_vlds(1, 300, ok);
        wait_quiet(400, ok);
        build_exp();
        n_checks++; if (wrt_c.size() != 4) $display("FAIL spur_rd_count: got %0d want 4", wrt_c.size()); else n_pass++;
        bad = 0;
        foreach (wrt_c[i]) if (wrt_c[i] !== rd_exp[i % 4]) bad++;
        n_checks++; if (bad != 0) $display("FAIL spur_rd_order: got %0d wrong want 0", bad); else n_pass++;
        n_checks++; if (vld_e.size() != 1 || exp_e.size() != 1) $display("FAIL spur_vld_count: got %0d want 1", vld_e.size()); else n_pass++;
        if (vld_e.size() == 1 && exp_e.size() == 1) begin
            n_checks++;
            if (vld_p[0] !== exp_p[0] || vld_a[0] !== exp_a[0] || vld_e[0] != exp_e[0])
                $display("FAIL spur_sample: got %h/%h@%0d want %h/%h@%0d", vld_p[0], vld_a[0], vld_e[0], exp_p[0], exp_a[0], exp_e[0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int bad, k;
        clear_logs();
        INT = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        INT = 1'b0;
        k = 0;
        while (done_e.size() < 2 && k < 200) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (done_e.size() != 2 || vld_e.size() != 0) $display("FAIL rst_mid_point: got %0d dones want 2", done_e.size()); else n_pass++;
        n_checks++;
        if (wrt !== 1'b0 || cmd !== 16'h0 || vld !== 1'b0 || ptch_rt !== 16'h0 || AZ !== 16'h0)
            $display("FAIL rst_async_outputs: got %b %h %b %h %h want all zero", wrt, cmd, vld, ptch_rt, AZ);
        else n_pass++;
        repeat (3) @(posedge clk);
        clear_logs();
        release_reset();
        wait_wrts(3, 200, ok);
        INT = 1'b1;
        wait_wrts(5, 300, ok);
        INT = 1'b0;
        n_checks++; if (!ok) $display("FAIL rst_reinit_wrts: got %0d want 5", wrt_e.size()); else n_pass++;
        wait_vlds(1, 300, ok);
        wait_quiet(400, ok);
        build_exp();
        if (wrt_e.size() >= 5 && done_e.size() >= 4) begin
            n_checks++; if (wrt_e[0] - rel_edge != 16) $display("FAIL rst_first_wrt: got %0d want 16", wrt_e[0] - rel_edge); else n_pass++;
            bad = 0;
            for (int i = 0; i < 4; i++) if (wrt_c[i] !== init_exp[i]) bad++;
            n_checks++; if (bad != 0) $display("FAIL rst_init_cmds: got %0d wrong want 0", bad); else n_pass++;
            n_checks++; if (wrt_c[4] !== 16'hA200) $display("FAIL rst_first_read: got %h want a200", wrt_c[4]); else n_pass++;
            n_checks++; if (wrt_e[4] != done_e[3] + 1) $display("FAIL rst_read_after_init: got %0d want %0d", wrt_e[4], done_e[3] + 1); else n_pass++;
        end
        n_checks++; if (vld_e.size() != 1 || exp_e.size() != 1) $display("FAIL rst_vld_count: got %0d want 1", vld_e.size()); else n_pass++;
        if (vld_e.size() == 1 && exp_e.size() == 1) begin
            n_checks++;
            if (vld_p[0] !== exp_p[0] || vld_a[0] !== exp_a[0])
                $display("FAIL rst_new_sample: got %h/%h want %h/%h", vld_p[0], vld_a[0], exp_p[0], exp_a[0]);
            else n_pass++;
        end
        n_checks++; if (leak_errs != 0) $display("FAIL rst_leak: got %0d want 0", leak_errs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init_int_early();
        test_single_read();
        test_back_to_back();
        test_spurious();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
